msc4_bus_master: RTL and testbench

CPU-side initiator for the MSC-4 4-bit multiplexed bus: drives the eight-phase instruction cycle (A1, A2, A3, M1, M2, X1, X2, X3), presents the 12-bit fetch address on D, strobes SYNC and CM, and captures the OPR and OPA nibbles returned by the ROM/I/O chips. In the X phases it also services SRC, WRR and RDR by sending the chip/port address, sending accumulator data, or sampling port data. The block sits between the CPU execution core and the shared D[3:0]/SYNC/CM bus.

---
 rtl/msc4_bus_master_if.sv | 29 ++
 rtl/msc4_bus_master.sv | 137 +++++++++++++
 tb/tb_msc4_bus_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/msc4_bus_master_if.sv
// MSC-4 bus master interface: core-side controls plus the multiplexed D/SYNC/CM bus.
// Port names follow the MSC-4 pin naming used by the rest of the CPU.
interface msc4_bus_master_if;
    logic        RUN;
    logic [11:0] PC;
    logic [3:0]  ACC;
    logic [7:0]  SRC_ADDR;
    logic [3:0]  D_IN;
    logic [3:0]  D_OUT;
    logic        D_OE;
    logic        SYNC;
    logic        CM;
    logic [3:0]  OPR;
    logic [3:0]  OPA;
    logic        INSTR_VALID;
    logic [3:0]  RD_DATA;
    logic        RD_VALID;
    logic [3:0]  PHASE;

    modport master (
        input  RUN, PC, ACC, SRC_ADDR, D_IN,
        output D_OUT, D_OE, SYNC, CM, OPR, OPA, INSTR_VALID, RD_DATA, RD_VALID, PHASE
    );

    modport slave (
        output RUN, PC, ACC, SRC_ADDR, D_IN,
        input  D_OUT, D_OE, SYNC, CM, OPR, OPA, INSTR_VALID, RD_DATA, RD_VALID, PHASE
    );
endinterface

// File: rtl/msc4_bus_master.sv
// MSC-4 bus master: eight-phase instruction cycle sequencer with opcode capture.
// Optional feature macro: MSC4_IO_CYCLES_EN enables the SRC/WRR/RDR X-phase
// bus cycles and the M2 CM strobe; without it only the fetch is performed.
module msc4_bus_master (
    input  logic             CLK0,
    input  logic             RESET,
    msc4_bus_master_if.master bus
);

    typedef enum logic [3:0] {
        S_A1   = 4'd0,
        S_A2   = 4'd1,
        S_A3   = 4'd2,
        S_M1   = 4'd3,
        S_M2   = 4'd4,
        S_X1   = 4'd5,
        S_X2   = 4'd6,
        S_X3   = 4'd7,
        S_IDLE = 4'd8
    } state_t;

    state_t     state;
    logic [7:0] pc_hi;   // PC[11:4], sent in A2/A3

`ifdef MSC4_IO_CYCLES_EN
    logic [3:0] src_lo;  // SRC_ADDR[3:0], sent in X3
    logic       is_src;
    logic       is_wrr;
    logic       is_rdr;

    // Decode of the fetched opcode for the I/O X-phase cycles
    always_comb begin
        is_src = (bus.OPR == 4'h2) && bus.OPA[0];
        is_wrr = (bus.OPR == 4'hE) && (bus.OPA == 4'h2);
        is_rdr = (bus.OPR == 4'hE) && (bus.OPA == 4'hA);
    end
`endif

    assign bus.PHASE = state;

    // Phase sequencer; every output is set on the edge entering the cycle it describes
    always_ff @(posedge CLK0 or posedge RESET) begin
        if (RESET) begin
            state           <= S_IDLE;
            pc_hi           <= 8'h00;
            bus.D_OUT       <= 4'h0;
            bus.D_OE        <= 1'b0;
            bus.SYNC        <= 1'b1;
            bus.CM          <= 1'b1;
            bus.OPR         <= 4'h0;
            bus.OPA         <= 4'h0;
            bus.INSTR_VALID <= 1'b0;
            bus.RD_DATA     <= 4'h0;
            bus.RD_VALID    <= 1'b0;
`ifdef MSC4_IO_CYCLES_EN
            src_lo          <= 4'h0;
`endif
        end else begin
            bus.D_OUT       <= 4'h0;
            bus.D_OE        <= 1'b0;
            bus.SYNC        <= 1'b1;
            bus.CM          <= 1'b1;
            bus.INSTR_VALID <= 1'b0;
            bus.RD_VALID    <= 1'b0;
            case (state)
                S_IDLE, S_X3: begin
                    if (bus.RUN) begin
                        state     <= S_A1;
                        pc_hi     <= bus.PC[11:4];
                        bus.D_OUT <= bus.PC[3:0];
                        bus.D_OE  <= 1'b1;
                        bus.SYNC  <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_A1: begin
                    state     <= S_A2;
                    bus.D_OUT <= pc_hi[3:0];
                    bus.D_OE  <= 1'b1;
                end
                S_A2: begin
                    state     <= S_A3;
                    bus.D_OUT <= pc_hi[7:4];
                    bus.D_OE  <= 1'b1;
                    bus.CM    <= 1'b0;
                end
                S_A3: begin
                    state <= S_M1;
                end
                S_M1: begin
                    state   <= S_M2;
                    bus.OPR <= bus.D_IN;
`ifdef MSC4_IO_CYCLES_EN
                    bus.CM  <= (bus.D_IN != 4'hE);
`endif
                end
                S_M2: begin
                    state           <= S_X1;
                    bus.OPA         <= bus.D_IN;
                    bus.INSTR_VALID <= 1'b1;
                end
                S_X1: begin
                    state <= S_X2;
`ifdef MSC4_IO_CYCLES_EN
                    src_lo <= bus.SRC_ADDR[3:0];
                    if (is_src) begin
                        bus.D_OUT <= bus.SRC_ADDR[7:4];
                        bus.D_OE  <= 1'b1;
                        bus.CM    <= 1'b0;
                    end else if (is_wrr) begin
                        bus.D_OUT <= bus.ACC;
                        bus.D_OE  <= 1'b1;
                    end
`endif
                end
                S_X2: begin
                    state <= S_X3;
`ifdef MSC4_IO_CYCLES_EN
                    if (is_src) begin
                        bus.D_OUT <= src_lo;
                        bus.D_OE  <= 1'b1;
                    end
                    if (is_rdr) begin
                        bus.RD_DATA  <= bus.D_IN;
                        bus.RD_VALID <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msc4_bus_master.sv
// Testbench for msc4_bus_master: directed table, randomized instructions
// against a phase-level reference model, and reset/RUN corner sequences.
module tb_msc4_bus_master;

`ifdef MSC4_IO_CYCLES_EN
    localparam bit IO = 1'b1;
`else
    localparam bit IO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    msc4_bus_master_if bus ();

    msc4_bus_master dut (
        .CLK0  (clk),
        .RESET (rst),
        .bus   (bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    // persistent model state for the captured registers
    logic [3:0] m_opr, m_opa, m_rd;

    typedef struct packed {
        logic [3:0] phase;
        logic       sync;
        logic       cm;
        logic       oe;
        logic [3:0] dout;
        logic       iv;
        logic [3:0] opr;
        logic [3:0] opa;
        logic       rv;
        logic [3:0] rd;
    } outs_t;

    typedef struct {
        logic [11:0] pc;
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic [3:0]  acc;
        logic [7:0]  src;
        logic [3:0]  rdv;
        logic        x2_oe;
        logic [3:0]  x2_d;
        logic        x2_cm;
    } instr_t;

    function automatic outs_t idle_exp();
        outs_t e;
        e.phase = 4'd8; e.sync = 1'b1; e.cm = 1'b1; e.oe = 1'b0; e.dout = 4'h0;
        e.iv = 1'b0; e.opr = m_opr; e.opa = m_opa; e.rv = 1'b0; e.rd = m_rd;
        return e;
    endfunction

    // Expected bus/outputs during cycle k (0=A1 .. 7=X3) of instruction r
    function automatic outs_t expect_cycle(int k, instr_t r);
        outs_t e;
        bit src, wrr, rdr;
        src = (r.opr == 4'h2) && r.opa[0];
        wrr = (r.opr == 4'hE) && (r.opa == 4'h2);
        rdr = (r.opr == 4'hE) && (r.opa == 4'hA);
        e.phase = 4'(k);
        e.sync  = (k != 0);
        e.oe    = 1'b0;
        e.dout  = 4'h0;
        e.cm    = 1'b1;
        case (k)
            0: begin e.oe = 1'b1; e.dout = r.pc[3:0]; end
            1: begin e.oe = 1'b1; e.dout = r.pc[7:4]; end
            2: begin e.oe = 1'b1; e.dout = r.pc[11:8]; e.cm = 1'b0; end
            4: e.cm = !(IO && r.opr == 4'hE);
            6: if (IO && src) begin e.oe = 1'b1; e.dout = r.src[7:4]; e.cm = 1'b0; end
               else if (IO && wrr) begin e.oe = 1'b1; e.dout = r.acc; end
            7: if (IO && src) begin e.oe = 1'b1; e.dout = r.src[3:0]; end
            default: ;
        endcase
        e.iv  = (k == 5);
        e.rv  = IO && rdr && (k == 7);
        e.opr = m_opr;
        e.opa = m_opa;
        e.rd  = m_rd;
        return e;
    endfunction

    function automatic outs_t actual();
        outs_t a;
        a.phase = bus.PHASE; a.sync = bus.SYNC; a.cm = bus.CM; a.oe = bus.D_OE;
        a.dout  = bus.D_OE ? bus.D_OUT : 4'h0;
        a.iv = bus.INSTR_VALID; a.opr = bus.OPR; a.opa = bus.OPA;
        a.rv = bus.RD_VALID; a.rd = bus.RD_DATA;
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_cycle(input string nm, input outs_t e);
        chk(nm, 32'(actual()), 32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction cycle from its A1 entry edge; stop_k < 8 aborts early
    task automatic run_instr(input instr_t r, input bit use_tab, input bit rand_run,
                             input int drop_at, input bit next_run, input int stop_k);
        for (int k = 0; k < stop_k; k++) begin
            bus.PC       = (k == 0) ? r.pc : 12'($urandom);
            bus.ACC      = (k == 6) ? r.acc : 4'($urandom);
            bus.SRC_ADDR = (k == 6) ? r.src : 8'($urandom);
            case (k)
                4:       bus.D_IN = r.opr;
                5:       bus.D_IN = r.opa;
                7:       bus.D_IN = r.rdv;
                default: bus.D_IN = 4'($urandom);
            endcase
            if (k == 0)            bus.RUN = 1'b1;
            else if (k >= drop_at) bus.RUN = 1'b0;
            else if (rand_run)     bus.RUN = 1'($urandom);
            else                   bus.RUN = 1'b1;
            tick();
            if (k == 4) m_opr = r.opr;
            if (k == 5) m_opa = r.opa;
            if (k == 7 && IO && r.opr == 4'hE && r.opa == 4'hA) m_rd = r.rdv;
            chk_cycle($sformatf("instr pc=%h op=%h%h k=%0d", r.pc, r.opr, r.opa, k),
                      expect_cycle(k, r));
            if (use_tab && k == 6)
                chk($sformatf("x2_table pc=%h", r.pc),
                    32'({bus.D_OE, bus.D_OE ? bus.D_OUT : 4'h0, bus.CM}),
                    32'({r.x2_oe, r.x2_d, r.x2_cm}));
        end
        bus.RUN = next_run;
    endtask

    instr_t tab [5];
    instr_t r;

    initial begin
        rst = 1'b1;
        bus.RUN = 1'b0; bus.PC = 12'h0; bus.ACC = 4'h0; bus.SRC_ADDR = 8'h0; bus.D_IN = 4'h0;
        m_opr = 4'h0; m_opa = 4'h0; m_rd = 4'h0;

        // directed records: fetch, SRC, WRR, RDR, non-SRC opcode 2
        tab[0] = '{12'h3A5, 4'hD, 4'h7, 4'h0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b1};
        tab[1] = '{12'h123, 4'h2, 4'h1, 4'h5, 8'hC4, 4'h0,
                   IO, IO ? 4'hC : 4'h0, !IO};
        tab[2] = '{12'h0F0, 4'hE, 4'h2, 4'h9, 8'h37, 4'h0,
                   IO, IO ? 4'h9 : 4'h0, 1'b1};
        tab[3] = '{12'hABC, 4'hE, 4'hA, 4'h3, 8'h5A, 4'h6, 1'b0, 4'h0, 1'b1};
        tab[4] = '{12'hFFF, 4'h2, 4'h0, 4'hF, 8'hFF, 4'h0, 1'b0, 4'h0, 1'b1};

        #12;
        chk_cycle("reset_held", idle_exp());
        chk("reset_dout", 32'(bus.D_OUT), 32'h0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.PC = 12'($urandom);
            tick();
            chk_cycle($sformatf("idle_run0 %0d", i), idle_exp());
            chk("idle_dout", 32'(bus.D_OUT), 32'h0);
        end

        for (int i = 0; i < 5; i++)
            run_instr(tab[i], 1'b1, 1'b0, 8, 1'b1, 8);

        for (int i = 0; i < 40; i++) begin
            r.pc  = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       r.opr = 4'h2;
                1:       r.opr = 4'hE;
                default: r.opr = 4'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0:       r.opa = (r.opr == 4'hE) ? 4'h2 : 4'h1;
                1:       r.opa = (r.opr == 4'hE) ? 4'hA : 4'h0;
                default: r.opa = 4'($urandom);
            endcase
            r.acc = 4'($urandom); r.src = 8'($urandom); r.rdv = 4'($urandom);
            r.x2_oe = 1'b0; r.x2_d = 4'h0; r.x2_cm = 1'b1;
            run_instr(r, 1'b0, 1'b1, 8, 1'b1, 8);
        end

        // RUN dropped during X1: instruction finishes through X3, then IDLE
        r = '{12'h5C3, 4'h2, 4'h3, 4'h1, 8'hB6, 4'h0, 1'b0, 4'h0, 1'b1};
        run_instr(r, 1'b0, 1'b0, 6, 1'b0, 8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cycle($sformatf("run_drop_idle %0d", i), idle_exp());
        end

        // RESET asserted in M2: immediate IDLE, no INSTR_VALID afterwards
        r = '{12'h777, 4'hE, 4'hA, 4'h2, 8'h11, 4'h9, 1'b0, 4'h0, 1'b1};
        run_instr(r, 1'b0, 1'b0, 8, 1'b1, 5);
        #2 rst = 1'b1;
        #1;
        m_opr = 4'h0; m_opa = 4'h0; m_rd = 4'h0;
        chk_cycle("reset_in_m2", idle_exp());
        @(negedge clk);
        bus.RUN = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cycle($sformatf("post_reset_idle %0d", i), idle_exp());
        end

        // recovery fetch after reset, then stop
        run_instr(tab[3], 1'b1, 1'b0, 8, 1'b0, 8);
        tick();
        chk_cycle("final_idle", idle_exp());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
